// File: rtl/operand_seq_pkg.sv
// operand_seq_pkg: shared state encoding, op-code constants and data width for operand_seq.
package operand_seq_pkg;
  localparam int DW = 32;
  localparam int CW = 16;
  typedef enum logic [1:0] {IDLE, GET_B, EXEC, HOLD} state_e;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;
endpackage

// File: rtl/operand_seq_if.sv
// operand_seq_if: operand upstream, element/MUX loop and result downstream signals.
// The zero port exists only when ZERO_FLAG_EN is defined.
interface operand_seq_if;
  import operand_seq_pkg::*;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [2:0]    in_op;
  logic          in_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [2:0]    op;
  logic [DW-1:0] res_in;
  logic [DW-1:0] res;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] ops_done;
`ifdef ZERO_FLAG_EN
  logic          zero;
`endif
  modport slave (
    input  in_valid, in_data, in_op, res_in, res_ready,
`ifdef ZERO_FLAG_EN
    output zero,
`endif
    output in_ready, A, B, op, res, res_valid, ops_done
  );
  modport master (
    output in_valid, in_data, in_op, res_in, res_ready,
`ifdef ZERO_FLAG_EN
    input  zero,
`endif
    input  in_ready, A, B, op, res, res_valid, ops_done
  );
endinterface

// File: rtl/operand_seq_reg32_en.sv
// reg32_en: 32-bit register with synchronous active-high reset and load enable.
module reg32_en
  import operand_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else if (en_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/operand_seq.sv
// operand_seq: collects operand A, then B with op, returns the registered element result over a valid/ready handshake.
// Optional ZERO_FLAG_EN adds a registered zero flag captured with the result.
module operand_seq
  import operand_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  operand_seq_if.slave bus
);
  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] ops_done_q, ops_done_d;
  logic [DW-1:0] a_q, b_q, res_q;
  logic          in_ready, res_valid, res_hs;
  logic          ld_a, ld_b, ld_res;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_res    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        ld_a     = bus.in_valid;
        state_d  = bus.in_valid ? GET_B : IDLE;
      end
      GET_B: begin
        in_ready = 1'b1;
        ld_b     = bus.in_valid;
        state_d  = bus.in_valid ? EXEC : GET_B;
      end
      EXEC: begin
        ld_res  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        state_d   = bus.res_ready ? IDLE : HOLD;
      end
    endcase
  end

  assign res_hs     = res_valid & bus.res_ready;
  assign op_d       = ld_b ? bus.in_op : op_q;
  assign ops_done_d = res_hs ? ops_done_q + 1'b1 : ops_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_AND;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ops_done_q <= ops_done_d;
    end
  end

  reg32_en u_a   (.clk(clk), .rst(rst), .en_i(ld_a),   .d_i(bus.in_data), .q_o(a_q));
  reg32_en u_b   (.clk(clk), .rst(rst), .en_i(ld_b),   .d_i(bus.in_data), .q_o(b_q));
  reg32_en u_res (.clk(clk), .rst(rst), .en_i(ld_res), .d_i(bus.res_in),  .q_o(res_q));

`ifdef ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else if (ld_res) zero_q <= (bus.res_in == '0);
  end
  assign bus.zero = zero_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.op        = op_q;
  assign bus.res       = res_q;
  assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_operand_seq.sv
// tb_operand_seq: scoreboard bench for operand_seq with a reference element/MUX looped onto res_in.
// Define ZERO_FLAG_EN to also exercise the zero flag.
module tb_operand_seq;
  import operand_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  always #5 clk = ~clk;
  operand_seq_if bus();
  operand_seq dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] o);
    case (o)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRL:  return a >> b[4:0];
      OP_SUB:  return a - b;
      default: return {31'b0, $signed(a) < $signed(b)};
    endcase
  endfunction

  assign bus.res_in = ref_alu(bus.A, bus.B, bus.op);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send(logic [31:0] d, logic [2:0] o, string tag);
    int k;
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_op = o;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_accept"}, 32'(k < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_b(logic [31:0] a, logic [31:0] b, logic [2:0] o);
    send(b, o, "b");
    chk("b_latched", bus.B, b);
    chk("op_latched", 32'(bus.op), 32'(o));
    chk("a_kept", bus.A, a);
    exp_q.push_back(ref_alu(a, b, o));
    chk("lat_edge1", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic start_op(logic [31:0] a, logic [31:0] b, logic [2:0] o);
    send(a, OP_AND, "a");
    chk("a_latched", bus.A, a);
    start_b(a, b, o);
  endtask

  task automatic finish_op(int stall);
    logic [31:0] r0;
    int k;
    k = 0;
    while (!bus.res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("res_valid_seen", 32'(bus.res_valid), 32'd1);
    r0 = bus.res;
    repeat (stall) begin
      @(negedge clk);
      chk("hold_res", bus.res, r0);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    if (exp_q.size() > 0) chk("res", bus.res, exp_q.pop_front());
    else chk("res_unexpected", 32'(exp_q.size()), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_cnt++;
    chk("ops_done", 32'(bus.ops_done), 32'(exp_cnt));
    chk("back_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_op = '0;
    bus.res_ready = 1'b0;
    bus.in_data = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    chk("rst_A", bus.A, 32'h0);
    chk("rst_B", bus.B, 32'h0);
    chk("rst_res", bus.res, 32'h0);
    chk("rst_op", 32'(bus.op), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_ops_done", 32'(bus.ops_done), 32'h0);
`ifdef ZERO_FLAG_EN
    chk("rst_zero", 32'(bus.zero), 32'h0);
`endif
    rst = 1'b0;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    // Basic AND with the element looped back through res_in
    start_op(32'hFFFF0000, 32'h0F0F0F0F, OP_AND);
    chk("basic_res", bus.res, 32'h0F0F0000);
    finish_op(0);
    chk("basic_count", 32'(bus.ops_done), 32'd1);
    for (int i = 0; i < 8; i++) begin
      start_op($urandom, $urandom, 3'(i));
      finish_op(i % 3);
    end
    // Backpressure with a word offered during HOLD
    start_op(32'h11111111, 32'h22222222, OP_ADD);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h12345678;
    bus.in_op = OP_AND;
    finish_op(5);
    chk("hold_ignored_A", bus.A, 32'h11111111);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_take_A", bus.A, 32'h12345678);
    start_b(32'h12345678, 32'h00000001, OP_OR);
    finish_op(0);
    // res_ready held high outside HOLD
    bus.res_ready = 1'b1;
    send(32'h00000005, OP_AND, "a_rr");
    chk("rr_no_count", 32'(bus.ops_done), 32'(exp_cnt));
    start_b(32'h00000005, 32'h00000007, OP_SUB);
    finish_op(0);
    // Reset in GET_B
    send(32'hDEADBEEF, OP_AND, "a_mid");
    chk("mid_A", bus.A, 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    chk("mid_A_clr", bus.A, 32'h0);
    chk("mid_idle", 32'(dut.state_q == IDLE), 32'd1);
    repeat (4) begin
      chk("mid_no_valid", 32'(bus.res_valid), 32'd0);
      @(negedge clk);
    end
    chk("mid_ops_done", 32'(bus.ops_done), 32'd0);
    start_op(32'h00000003, 32'h00000004, OP_SLT);
    finish_op(1);
    // Counter wrap
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    exp_cnt = 16'hFFFF;
    start_op(32'h00000010, 32'h00000002, OP_SRL);
    finish_op(0);
    chk("wrap_zero", 32'(bus.ops_done), 32'h0);
`ifdef ZERO_FLAG_EN
    start_op(32'hAAAAAAAA, 32'h55555555, OP_AND);
    chk("zero_res", bus.res, 32'h0);
    chk("zero_set", 32'(bus.zero), 32'd1);
    finish_op(0);
    start_op(32'h00000001, 32'h00000001, OP_AND);
    chk("zero_clr", 32'(bus.zero), 32'd0);
    finish_op(0);
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
